divider: RTL

DIVIDER -- requirements
Module: divider

---
 rtl/divider_pkg.sv | 13 +
 rtl/divider_div_step.sv | 35 +++
 rtl/divider.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/divider_pkg.sv
// Shared state encoding and default operand width for the iterative divider.
package divider_pkg;

  localparam int DIV_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } div_state_e;

endpackage : divider_pkg

// File: rtl/divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference only when it does not go negative.
module div_step
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] pr,
  input  logic [WIDTH-1:0] dvs,
  input  logic             bit_in,
  output logic [WIDTH-1:0] pr_next,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted_s;
  logic [WIDTH-1:0] diff_s;

  // When the subtraction succeeds the true difference is below dvs, so W bits hold it.
  assign shifted_s = {pr, bit_in};
  assign diff_s    = shifted_s[WIDTH-1:0] - dvs;

  // Restore-or-subtract decision.
  always_comb begin
    pr_next = shifted_s[WIDTH-1:0];
    q_bit   = 1'b0;
    if (shifted_s >= {1'b0, dvs}) begin
      pr_next = diff_s;
      q_bit   = 1'b1;
    end else begin
      pr_next = shifted_s[WIDTH-1:0];
      q_bit   = 1'b0;
    end
  end

endmodule : div_step

// File: rtl/divider.sv
// Multi-cycle signed/unsigned restoring divider: WIDTH iterations on magnitudes,
// one sign-fix cycle, then a held result until the next accepted operation.
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             is_signed,
  input  logic             valid_in,
  input  logic             flush,
  output logic             ready,
  output logic             valid_out,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  div_state_e       state_r, state_s;
  logic [CNT_W-1:0] cnt_r;
  logic             ready_r;
  logic             valid_out_r;
  logic [WIDTH-1:0] quot_r, rem_r;
  logic [WIDTH-1:0] dq_r;
  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH-1:0] pr_r;
  logic             neg_q_r, neg_rem_r;

  logic             accept_s;
  logic             neg_a_s, neg_b_s, b_zero_s;
  logic [WIDTH-1:0] pr_next_s;
  logic             q_bit_s;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    if (neg) begin
      return -v;
    end else begin
      return v;
    end
  endfunction

  assign accept_s = valid_in && ready_r && !flush;
  assign neg_a_s  = is_signed && A[WIDTH-1];
  assign neg_b_s  = is_signed && B[WIDTH-1];
  assign b_zero_s = (B == {WIDTH{1'b0}});

  div_step #(.WIDTH(WIDTH)) u_step (
    .pr      (pr_r),
    .dvs     (dvs_r),
    .bit_in  (dq_r[WIDTH-1]),
    .pr_next (pr_next_s),
    .q_bit   (q_bit_s)
  );

  // Next-state logic; flush overrides everything including a new request.
  always_comb begin
    state_s = state_r;
    if (flush) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_s = accept_s ? CALC : IDLE;
        CALC:    state_s = (cnt_r == CNT_LAST) ? FIX : CALC;
        FIX:     state_s = DONE;
        DONE:    state_s = accept_s ? CALC : DONE;
        default: state_s = IDLE;
      endcase
    end
  end

  // Control registers: state, iteration counter, handshake flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      ready_r     <= 1'b1;
      valid_out_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      ready_r     <= (state_s == IDLE) || (state_s == DONE);
      valid_out_r <= (state_r == DONE) && !accept_s && !flush;
      if (accept_s || flush) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (state_r == CALC) begin
        cnt_r <= (cnt_r == CNT_LAST) ? {CNT_W{1'b0}} : cnt_r + CNT_ONE;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Iteration datapath; dq_r shifts dividend bits out and quotient bits in.
  // A zero divisor yields all-ones quotient and the dividend magnitude as remainder.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dq_r      <= {WIDTH{1'b0}};
      dvs_r     <= {WIDTH{1'b0}};
      pr_r      <= {WIDTH{1'b0}};
      neg_q_r   <= 1'b0;
      neg_rem_r <= 1'b0;
    end else if (accept_s) begin
      dq_r      <= cond_neg(A, neg_a_s);
      dvs_r     <= cond_neg(B, neg_b_s);
      pr_r      <= {WIDTH{1'b0}};
      neg_q_r   <= (neg_a_s ^ neg_b_s) && !b_zero_s;
      neg_rem_r <= neg_a_s;
    end else if ((state_r == CALC) && !flush) begin
      dq_r      <= {dq_r[WIDTH-2:0], q_bit_s};
      pr_r      <= pr_next_s;
    end else begin
      dq_r      <= dq_r;
      pr_r      <= pr_r;
    end
  end

  // Sign correction into the held result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quot_r <= {WIDTH{1'b0}};
      rem_r  <= {WIDTH{1'b0}};
    end else if ((state_r == FIX) && !flush) begin
      quot_r <= cond_neg(dq_r, neg_q_r);
      rem_r  <= cond_neg(pr_r, neg_rem_r);
    end else begin
      quot_r <= quot_r;
      rem_r  <= rem_r;
    end
  end

  assign ready     = ready_r;
  assign valid_out = valid_out_r;
  assign quot      = quot_r;
  assign rem       = rem_r;

endmodule : divider
